// File: rtl/rect_fill_issuer_pkg.sv
// Shared widths, instruction field positions and FSM encodings for the rectangle
// fill issuer and any other plot-instruction source.
package rect_fill_issuer_pkg;
  localparam int X_COORD_WIDTH     = 8;
  localparam int Y_COORD_WIDTH     = 7;
  localparam int COLOUR_WIDTH      = 3;
  localparam int OPCODE_WIDTH      = 3;
  localparam int INSTRUCTION_WIDTH = 22;

  localparam int PLOT_BIT   = 18;
  localparam int COLOUR_LSB = 15;
  localparam int Y_LSB      = 8;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_PLOT = 3'd1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct packed {
    logic [X_COORD_WIDTH-1:0] x;
    logic [Y_COORD_WIDTH-1:0] y;
    logic [X_COORD_WIDTH-1:0] w;
    logic [Y_COORD_WIDTH-1:0] h;
    logic [COLOUR_WIDTH-1:0]  colour;
    logic                     plot;
  } rect_cmd_t;
endpackage

// File: rtl/rect_fill_issuer_plot_instr_encoder.sv
// Packs a pixel (x, y, colour, plot) into a datapath instruction; all unused bits are 0.
module plot_instr_encoder
  import rect_fill_issuer_pkg::*;
#(
  parameter logic [OPCODE_WIDTH-1:0] OPC = OPCODE_PLOT
) (
  input  logic [X_COORD_WIDTH-1:0]     x,
  input  logic [Y_COORD_WIDTH-1:0]     y,
  input  logic [COLOUR_WIDTH-1:0]      colour,
  input  logic                         plot,
  output logic [INSTRUCTION_WIDTH-1:0] instr
);
  always_comb begin
    instr                                        = '0;
    instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH]   = OPC;
    instr[PLOT_BIT]                              = plot;
    instr[COLOUR_LSB +: COLOUR_WIDTH]            = colour;
    instr[Y_LSB +: Y_COORD_WIDTH]                = y;
    instr[X_COORD_WIDTH-1:0]                     = x;
  end
endmodule

// File: rtl/rect_fill_issuer.sv
// Walks one filled-rectangle command row-major and hands each on-screen pixel to the
// datapath as a plot instruction, waiting for the datapath between pixels.
module rect_fill_issuer
  import rect_fill_issuer_pkg::*;
#(
  parameter int                      X_MAX    = 159,
  parameter int                      Y_MAX    = 119,
  parameter logic [OPCODE_WIDTH-1:0] OPC_PLOT = OPCODE_PLOT
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [X_COORD_WIDTH-1:0]     cmd_x,
  input  logic [Y_COORD_WIDTH-1:0]     cmd_y,
  input  logic [X_COORD_WIDTH-1:0]     cmd_w,
  input  logic [Y_COORD_WIDTH-1:0]     cmd_h,
  input  logic [COLOUR_WIDTH-1:0]      cmd_colour,
  input  logic                         cmd_plot,
  input  logic                         abort,
  input  logic                         dp_finished,
  output logic                         dp_start,
  output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
  output logic                         busy,
  output logic                         done
);
  localparam logic [X_COORD_WIDTH:0]   X_LIM = X_MAX[X_COORD_WIDTH:0];
  localparam logic [Y_COORD_WIDTH:0]   Y_LIM = Y_MAX[Y_COORD_WIDTH:0];
  localparam logic [X_COORD_WIDTH-1:0] X_ONE = 1;
  localparam logic [Y_COORD_WIDTH-1:0] Y_ONE = 1;

  logic [2:0]                   state_q, state_d;
  rect_cmd_t                    cmd_q, cmd_d;
  logic [X_COORD_WIDTH-1:0]     col_q, col_d;
  logic [Y_COORD_WIDTH-1:0]     row_q, row_d;
  logic                         start_q, start_d;
  logic                         first_q, first_d;
  logic                         abort_pend_q, abort_pend_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d, instr_enc;

  // One extra bit on each sum so a carry reads as off-screen rather than wrapping.
  logic [X_COORD_WIDTH:0] px;
  logic [Y_COORD_WIDTH:0] py;
  logic                   on_screen, col_last, row_last;

  assign px        = {1'b0, cmd_q.x} + {1'b0, col_q};
  assign py        = {1'b0, cmd_q.y} + {1'b0, row_q};
  assign on_screen = (px <= X_LIM) && (py <= Y_LIM);
  assign col_last  = (col_q == cmd_q.w - X_ONE);
  assign row_last  = (row_q == cmd_q.h - Y_ONE);

  plot_instr_encoder #(.OPC(OPC_PLOT)) u_enc (
    .x      (px[X_COORD_WIDTH-1:0]),
    .y      (py[Y_COORD_WIDTH-1:0]),
    .colour (cmd_q.colour),
    .plot   (cmd_q.plot),
    .instr  (instr_enc)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    col_d        = col_q;
    row_d        = row_q;
    start_d      = 1'b0;
    first_d      = 1'b0;
    abort_pend_d = abort_pend_q;
    instr_d      = instr_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        cmd_d        = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h,
                         colour: cmd_colour, plot: cmd_plot};
        col_d        = '0;
        row_d        = '0;
        abort_pend_d = 1'b0;
        state_d      = (cmd_w == '0 || cmd_h == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)               state_d = S_DONE;
        else if (!on_screen)     state_d = S_STEP;
        else if (dp_finished) begin
          instr_d = instr_enc;
          start_d = 1'b1;
          first_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) abort_pend_d = 1'b1;
        // finished is still high from the previous pixel on the entry cycle
        if (!first_q && dp_finished)
          state_d = (abort || abort_pend_q) ? S_DONE : S_STEP;
      end
      S_STEP: begin
        if (abort) state_d = S_DONE;
        else begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + Y_ONE;
          end else begin
            col_d = col_q + X_ONE;
          end
          state_d = (col_last && row_last) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      start_q      <= 1'b0;
      first_q      <= 1'b0;
      abort_pend_q <= 1'b0;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      col_q        <= col_d;
      row_q        <= row_d;
      start_q      <= start_d;
      first_q      <= first_d;
      abort_pend_q <= abort_pend_d;
      instr_q      <= instr_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign dp_start       = start_q;
  assign dp_instruction = instr_q;
endmodule

// File: tb/tb_rect_fill_issuer.sv
// Directed bench: a model datapath, a queue of expected instructions popped on every
// dp_start, and cycle/pulse checks around each command.
module tb_rect_fill_issuer;
  import rect_fill_issuer_pkg::*;

  logic                         clock = 1'b0;
  logic                         resetn = 1'b0;
  logic                         cmd_valid = 1'b0;
  logic                         cmd_ready;
  logic [X_COORD_WIDTH-1:0]     cmd_x = '0;
  logic [Y_COORD_WIDTH-1:0]     cmd_y = '0;
  logic [X_COORD_WIDTH-1:0]     cmd_w = '0;
  logic [Y_COORD_WIDTH-1:0]     cmd_h = '0;
  logic [COLOUR_WIDTH-1:0]      cmd_colour = '0;
  logic                         cmd_plot = 1'b0;
  logic                         abort = 1'b0;
  logic                         dp_finished;
  logic                         dp_start;
  logic [INSTRUCTION_WIDTH-1:0] dp_instruction;
  logic                         busy;
  logic                         done;

  rect_fill_issuer dut (
    .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour), .cmd_plot(cmd_plot), .abort(abort),
    .dp_finished(dp_finished), .dp_start(dp_start), .dp_instruction(dp_instruction),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Model datapath: drops finished on the edge that sees start, raises it one cycle later.
  logic model_fin, hold_fin = 1'b0;
  always @(posedge clock or negedge resetn)
    if (!resetn)       model_fin <= 1'b1;
    else if (dp_start) model_fin <= 1'b0;
    else               model_fin <= 1'b1;
  assign dp_finished = model_fin & ~hold_fin;

  int tests = 0, fails = 0;
  int start_cnt = 0, done_cnt = 0;
  logic [INSTRUCTION_WIDTH-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INSTRUCTION_WIDTH-1:0] exp_instr(input int px, input int py,
      input logic [2:0] col, input logic pl);
    logic [7:0] xb;
    logic [6:0] yb;
    xb = px[7:0];
    yb = py[6:0];
    return {3'd1, pl, col, yb, xb};
  endfunction

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (dp_start) begin
      start_cnt++;
      if (sb.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
      else                chk("instr", 32'(dp_instruction), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Drives one command (accepted on the next rising edge) and queues its on-screen pixels.
  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [2:0] col, input logic pl, input int max_push);
    int pushed = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (x + c <= 159 && y + r <= 119 && pushed < max_push) begin
          sb.push_back(exp_instr(x + c, y + r, col, pl));
          pushed++;
        end
    cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h);
    cmd_colour = col; cmd_plot = pl; cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // n = number of falling edges after the accept edge up to and including the done one.
  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < limit);
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic check_idle(input string tag, input int done_before);
    tick();
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_ready"},     32'(cmd_ready), 32'd1);
    chk({tag, "_done_once"}, 32'(done_cnt),  32'(done_before + 1));
    chk({tag, "_sb_empty"},  32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n, d0, s0;
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_start", 32'(dp_start),  32'd0);
    chk("rst_instr", 32'(dp_instruction), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // 2x2 fully on-screen: 4 pixels at 5 cycles each, then done
    d0 = done_cnt;
    send(10, 20, 2, 2, 3'd5, 1'b1, 1000);
    chk("t1_busy_after_accept",  32'(busy),      32'd1);
    chk("t1_ready_after_accept", 32'(cmd_ready), 32'd0);
    wait_done("t1", 200, n);
    chk("t1_issue_cycles", 32'(n - 1), 32'd20);
    check_idle("t1", d0);

    // straddles both screen edges: 4 of 12 pixels issued, 8 skipped at 2 cycles each
    d0 = done_cnt; s0 = start_cnt;
    send(158, 118, 4, 3, 3'd2, 1'b0, 1000);
    wait_done("t2", 300, n);
    chk("t2_issue_cycles", 32'(n - 1), 32'd36);
    chk("t2_starts", 32'(start_cnt - s0), 32'd4);
    check_idle("t2", d0);

    // empty rectangle: done on the cycle after accept, nothing issued
    d0 = done_cnt; s0 = start_cnt;
    send(5, 5, 0, 5, 3'd1, 1'b1, 1000);
    wait_done("t3", 10, n);
    chk("t3_done_latency", 32'(n), 32'd1);
    chk("t3_starts", 32'(start_cnt - s0), 32'd0);
    check_idle("t3", d0);

    // datapath held busy: stall in ISSUE without starting
    d0 = done_cnt; s0 = start_cnt;
    hold_fin = 1'b1;
    send(30, 40, 2, 1, 3'd3, 1'b1, 1000);
    repeat (10) tick();
    chk("t4_stall_starts", 32'(start_cnt - s0), 32'd0);
    chk("t4_stall_busy",   32'(busy), 32'd1);
    hold_fin = 1'b0;
    wait_done("t4", 100, n);
    chk("t4_starts", 32'(start_cnt - s0), 32'd2);
    check_idle("t4", d0);

    // abort while the third pixel of a 4x4 is in flight
    d0 = done_cnt; s0 = start_cnt;
    send(0, 0, 4, 4, 3'd7, 1'b1, 3);
    n = 0;
    while (start_cnt - s0 < 3 && n < 100) begin tick(); n++; end
    chk("t5_reached_pixel3", 32'(start_cnt - s0), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("t5", 50, n);
    check_idle("t5", d0);
    repeat (4) tick();
    chk("t5_no_more_starts", 32'(start_cnt - s0), 32'd3);

    // asynchronous reset mid-WAIT, then a clean command
    s0 = start_cnt;
    send(1, 1, 2, 2, 3'd4, 1'b1, 1);
    n = 0;
    while (start_cnt == s0 && n < 100) begin tick(); n++; end
    chk("t6_in_wait_start", 32'(dp_start), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_start", 32'(dp_start),  32'd0);
    chk("t6_rst_busy",  32'(busy),      32'd0);
    chk("t6_rst_done",  32'(done),      32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
    sb.delete();
    tick(); tick();
    resetn = 1'b1;
    tick();
    d0 = done_cnt; s0 = start_cnt;
    send(5, 6, 1, 1, 3'd2, 1'b0, 1000);
    wait_done("t6", 50, n);
    chk("t6_issue_cycles", 32'(n - 1), 32'd5);
    chk("t6_starts", 32'(start_cnt - s0), 32'd1);
    check_idle("t6", d0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
